// File: rtl/asg_sweep_sequencer_pkg.sv
// Shared types and constants for the ASG sweep sequencer: FSM states,
// register offsets of the generator block and the trigger word layout.
package asg_sweep_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_STEP,
        S_WT_STEP,
        S_WR_TRIG,
        S_WT_TRIG,
        S_DWELL,
        S_NEXT,
        S_ERR
    } seq_state_t;

    localparam logic [31:0] REG_TRIG   = 32'h0000_0000;
    localparam logic [31:0] REG_STEP_A = 32'h0000_0010;
    localparam logic [31:0] REG_STEP_B = 32'h0000_0030;
    localparam logic [2:0]  TRIG_SRC   = 3'b001;

    // Channel A uses the low trigger field, channel B the same layout shifted by 16.
    function automatic logic [31:0] trig_word(input logic ch, input logic [4:0] ctrl);
        logic [31:0] w;
        w = '0;
        if (ch) begin
            w[24:20] = ctrl;
            w[18:16] = TRIG_SRC;
        end else begin
            w[8:4] = ctrl;
            w[2:0] = TRIG_SRC;
        end
        return w;
    endfunction

endpackage

// File: rtl/asg_seq_bus_master.sv
// Single-write bus master: issues one write, waits for ack, flags bus error
// or ack timeout.
module asg_seq_bus_master #(
    parameter int ACK_TMO = 16
) (
    input  logic        dac_clk_i,
    input  logic        dac_rst_i,
    input  logic        issue_i,
    input  logic        clear_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_wdata_o,
    output logic        m_wen_o,
    input  logic        m_ack_i,
    input  logic        m_err_i,
    output logic        done_o,
    output logic        fail_o
);

    localparam int TW = $clog2(ACK_TMO + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TMO - 1);

    logic          pending_q;
    logic [TW-1:0] tmo_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;

    // Handshake: m_wen_o is a one-cycle write strobe with address/data valid in
    // that cycle; address/data then stay held until the next strobe. The write
    // completes on the first cycle after the strobe with m_ack_i high; m_err_i
    // in that window, or ACK_TMO cycles since the strobe without ack, is a fail.
    assign m_wen_o   = issue_i;
    assign m_addr_o  = issue_i ? addr_i  : addr_q;
    assign m_wdata_o = issue_i ? wdata_i : wdata_q;
    assign done_o    = pending_q && m_ack_i && !m_err_i;
    assign fail_o    = pending_q && (m_err_i || (!m_ack_i && tmo_q >= TMO_LAST));

    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            pending_q <= 1'b0;
            tmo_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            if (issue_i) begin
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                tmo_q   <= TW'(1);
            end else if (pending_q && tmo_q < TMO_LAST) begin
                tmo_q <= tmo_q + TW'(1);
            end

            if (clear_i)
                pending_q <= 1'b0;
            else if (issue_i)
                pending_q <= 1'b1;
            else if (done_o || fail_o)
                pending_q <= 1'b0;
        end
    end

endmodule

// File: rtl/asg_sweep_sequencer.sv
// Steps an ASG channel through a frequency/phase sweep: per point it writes the
// step register, fires a trigger write, dwells, then advances or finishes.
module asg_sweep_sequencer
    import asg_sweep_sequencer_pkg::*;
#(
    parameter int ACK_TMO = 16,
    parameter int STW     = 30
) (
    input  logic             dac_clk_i,
    input  logic             dac_rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             cfg_ch_i,
    input  logic [STW-1:0]   cfg_start_i,
    input  logic [STW-1:0]   cfg_stop_i,
    input  logic [STW-1:0]   cfg_inc_i,
    input  logic [31:0]      cfg_dwell_i,
    input  logic [4:0]       cfg_ctrl_i,
    output logic [31:0]      m_addr_o,
    output logic [31:0]      m_wdata_o,
    output logic             m_wen_o,
    input  logic             m_ack_i,
    input  logic             m_err_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [15:0]      point_o,
    output seq_state_t       dbg_state_o
);

    seq_state_t     state_q, state_d;
    logic           ch_q;
    logic [STW-1:0] stop_q, inc_q, step_q;
    logic [31:0]    dwell_q, dwell_cnt_q;
    logic [4:0]     ctrl_q;
    logic [15:0]    point_q;
    logic           done_q, err_q;

    logic           issue;
    logic [31:0]    bm_addr, bm_wdata;
    logic           bm_done, bm_fail;
    logic [STW:0]   sum;
    logic           dwell_last;
    logic           adv, fin;

    asg_seq_bus_master #(.ACK_TMO(ACK_TMO)) u_bus (
        .dac_clk_i (dac_clk_i),
        .dac_rst_i (dac_rst_i),
        .issue_i   (issue),
        .clear_i   (abort_i),
        .addr_i    (bm_addr),
        .wdata_i   (bm_wdata),
        .m_addr_o  (m_addr_o),
        .m_wdata_o (m_wdata_o),
        .m_wen_o   (m_wen_o),
        .m_ack_i   (m_ack_i),
        .m_err_i   (m_err_i),
        .done_o    (bm_done),
        .fail_o    (bm_fail)
    );

    always_comb begin
        state_d    = state_q;
        issue      = 1'b0;
        bm_addr    = '0;
        bm_wdata   = '0;
        adv        = 1'b0;
        fin        = 1'b0;
        sum        = {1'b0, step_q} + {1'b0, inc_q};
        // A dwell of 0 behaves as 1 so every point is held at least one cycle.
        dwell_last = (dwell_q <= 32'd1) || (dwell_cnt_q == dwell_q - 32'd1);
        case (state_q)
            S_IDLE:    if (start_i) state_d = S_WR_STEP;
            S_WR_STEP: begin
                issue    = 1'b1;
                bm_addr  = ch_q ? REG_STEP_B : REG_STEP_A;
                bm_wdata = 32'(step_q);
                state_d  = S_WT_STEP;
            end
            S_WT_STEP: begin
                if (bm_fail)      state_d = S_ERR;
                else if (bm_done) state_d = S_WR_TRIG;
            end
            S_WR_TRIG: begin
                issue    = 1'b1;
                bm_addr  = REG_TRIG;
                bm_wdata = trig_word(ch_q, ctrl_q);
                state_d  = S_WT_TRIG;
            end
            S_WT_TRIG: begin
                if (bm_fail)      state_d = S_ERR;
                else if (bm_done) state_d = S_DWELL;
            end
            S_DWELL:   if (dwell_last) state_d = S_NEXT;
            S_NEXT: begin
                if (inc_q == '0 || sum[STW] || sum[STW-1:0] > stop_q) begin
                    fin     = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    adv     = 1'b1;
                    state_d = S_WR_STEP;
                end
            end
            S_ERR:     state_d = S_ERR;
            default:   state_d = S_IDLE;
        endcase
        // Abort overrides everything once busy, including a pending error/finish.
        if (abort_i && state_q != S_IDLE) begin
            state_d = S_IDLE;
            adv     = 1'b0;
            fin     = 1'b0;
        end
    end

    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            state_q     <= S_IDLE;
            ch_q        <= 1'b0;
            stop_q      <= '0;
            inc_q       <= '0;
            step_q      <= '0;
            dwell_q     <= '0;
            dwell_cnt_q <= '0;
            ctrl_q      <= '0;
            point_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dwell_cnt_q <= (state_q == S_DWELL) ? dwell_cnt_q + 32'd1 : '0;
            if (state_q == S_IDLE && start_i) begin
                ch_q    <= cfg_ch_i;
                stop_q  <= cfg_stop_i;
                inc_q   <= cfg_inc_i;
                step_q  <= cfg_start_i;
                dwell_q <= cfg_dwell_i;
                ctrl_q  <= cfg_ctrl_i;
                point_q <= '0;
                done_q  <= 1'b0;
                err_q   <= 1'b0;
            end
            if (adv) begin
                step_q <= sum[STW-1:0];
                if (point_q != 16'hFFFF) point_q <= point_q + 16'd1;
            end
            if (fin) done_q <= 1'b1;
            if (state_d == S_ERR) err_q <= 1'b1;
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign point_o     = point_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_asg_sweep_sequencer.sv
// Testbench for asg_sweep_sequencer: directed corner cases plus randomized
// sweeps compared against a list-of-writes reference model.
module tb_asg_sweep_sequencer;

    localparam int ACK_TMO = 16;
    localparam int STW     = 30;

    logic             dac_clk_i, dac_rst_i, start_i, abort_i, cfg_ch_i;
    logic [STW-1:0]   cfg_start_i, cfg_stop_i, cfg_inc_i;
    logic [31:0]      cfg_dwell_i;
    logic [4:0]       cfg_ctrl_i;
    logic [31:0]      m_addr_o, m_wdata_o;
    logic             m_wen_o, m_ack_i, m_err_i;
    logic             busy_o, done_o, err_o;
    logic [15:0]      point_o;
    logic [2:0]       dbg_state;

    asg_sweep_sequencer #(.ACK_TMO(ACK_TMO), .STW(STW)) dut (
        .dac_clk_i   (dac_clk_i),
        .dac_rst_i   (dac_rst_i),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .cfg_ch_i    (cfg_ch_i),
        .cfg_start_i (cfg_start_i),
        .cfg_stop_i  (cfg_stop_i),
        .cfg_inc_i   (cfg_inc_i),
        .cfg_dwell_i (cfg_dwell_i),
        .cfg_ctrl_i  (cfg_ctrl_i),
        .m_addr_o    (m_addr_o),
        .m_wdata_o   (m_wdata_o),
        .m_wen_o     (m_wen_o),
        .m_ack_i     (m_ack_i),
        .m_err_i     (m_err_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .point_o     (point_o),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    initial dac_clk_i = 1'b0;
    always #5 dac_clk_i = ~dac_clk_i;

    int cyc = 0;
    always @(posedge dac_clk_i) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge dac_clk_i);
    endtask

    // scoreboard: {addr, wdata} per write
    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];

    int ack_mode = 0;   // 0 ack, 1 never ack, 2 error response
    int lat_min  = 1;
    int lat_max  = 1;
    int ack_cnt  = 0;
    int last_ack_cyc = 0;
    int dwell_eff = 1;
    int sweep_wr  = 0;
    bit holding   = 1'b0;
    logic [31:0] hold_addr, hold_data;

    // bus monitor + slave responder, both on the falling edge
    initial begin
        m_ack_i = 1'b0;
        m_err_i = 1'b0;
        forever begin
            @(negedge dac_clk_i);
            if (m_ack_i) holding = 1'b0;
            if (m_wen_o) begin
                obs_q.push_back({m_addr_o, m_wdata_o});
                if (m_addr_o != 32'h0 && sweep_wr > 0)
                    check("dwell_gap", 64'(cyc - last_ack_cyc), 64'(dwell_eff + 2));
                sweep_wr++;
                hold_addr = m_addr_o;
                hold_data = m_wdata_o;
                holding   = 1'b1;
            end else if (holding && busy_o) begin
                check("hold_addr", m_addr_o, hold_addr);
                check("hold_data", m_wdata_o, hold_data);
            end
            m_ack_i = 1'b0;
            m_err_i = 1'b0;
            if (ack_cnt > 0) begin
                ack_cnt--;
                if (ack_cnt == 0) begin
                    m_ack_i = 1'b1;
                    m_err_i = (ack_mode == 2);
                    last_ack_cyc = cyc;
                end
            end
            if (m_wen_o && ack_mode != 1) ack_cnt = $urandom_range(lat_max, lat_min);
        end
    end

    // reference model: list of writes the sweep must produce
    task automatic model(input logic ch, input logic [4:0] ctrl, input logic [31:0] st,
                         input logic [31:0] sp, input logic [31:0] inc, output int npts);
        longint unsigned s, lim;
        logic [31:0] tw;
        lim = 64'd1 << STW;
        tw  = ch ? ((32'(ctrl) << 20) | 32'h0001_0000) : ((32'(ctrl) << 4) | 32'h1);
        s = 64'(st);
        npts = 0;
        exp_q.delete();
        forever begin
            exp_q.push_back({(ch ? 32'h30 : 32'h10), s[31:0]});
            exp_q.push_back({32'h0, tw});
            npts++;
            if (inc == 0 || s + inc >= lim || s + inc > 64'(sp)) break;
            s = s + inc;
        end
    endtask

    task automatic set_cfg(input logic ch, input logic [4:0] ctrl, input logic [31:0] st,
                           input logic [31:0] sp, input logic [31:0] inc, input logic [31:0] dw);
        cfg_ch_i    = ch;
        cfg_ctrl_i  = ctrl;
        cfg_start_i = STW'(st);
        cfg_stop_i  = STW'(sp);
        cfg_inc_i   = STW'(inc);
        cfg_dwell_i = dw;
        dwell_eff   = (dw == 0) ? 1 : int'(dw);
        sweep_wr    = 0;
        obs_q.delete();
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy_o && n < 5000) begin
            tick();
            n++;
        end
        check(tag, 64'(n < 5000), 64'd1);
    endtask

    task automatic run_sweep(input logic ch, input logic [4:0] ctrl, input logic [31:0] st,
                             input logic [31:0] sp, input logic [31:0] inc, input logic [31:0] dw,
                             input int lmax, input bit poke);
        int npts;
        ack_mode = 0;
        lat_min  = 1;
        lat_max  = lmax;
        set_cfg(ch, ctrl, st, sp, inc, dw);
        model(ch, ctrl, st, sp, inc, npts);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("busy_after_start", busy_o, 1);
        check("done_cleared", done_o, 0);
        cfg_ch_i    = 1'($urandom);
        cfg_start_i = STW'($urandom);
        cfg_stop_i  = STW'($urandom);
        cfg_inc_i   = STW'($urandom);
        cfg_dwell_i = $urandom_range(50, 0);
        cfg_ctrl_i  = 5'($urandom);
        if (poke) begin
            repeat ($urandom_range(8, 1)) tick();
            if (busy_o) begin
                start_i = 1'b1;
                tick();
                start_i = 1'b0;
            end
        end
        wait_idle("sweep_timeout");
        check("wr_count", 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check($sformatf("wr%0d", i), obs_q[i], exp_q[i]);
        check("done", done_o, 1);
        check("err", err_o, 0);
        check("point_final", point_o, 64'(npts - 1));
    endtask

    initial begin
        int n, t0, np;
        logic [31:0] st, sp, inc;
        $display("watchdog armed");
        dac_rst_i = 1'b1;
        start_i = 1'b0; abort_i = 1'b0;
        set_cfg(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        repeat (3) tick();
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        check("rst_wen", m_wen_o, 0);
        check("rst_addr", m_addr_o, 0);
        check("rst_wdata", m_wdata_o, 0);
        check("rst_point", point_o, 0);
        dac_rst_i = 1'b0;
        tick();

        // basic channel A sweep of three points
        run_sweep(1'b0, 5'd0, 32'h10000, 32'h30000, 32'h10000, 32'd4, 1, 1'b0);
        // channel B trigger layout
        run_sweep(1'b1, 5'b00001, 32'h10000, 32'h30000, 32'h10000, 32'd2, 1, 1'b0);
        // carry out of the step register
        run_sweep(1'b0, 5'h1F, 32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'd1, 32'd1, 2, 1'b0);
        // start beyond stop, and zero increment: one point each
        run_sweep(1'b1, 5'h0A, 32'h200, 32'h100, 32'd5, 32'd0, 3, 1'b0);
        run_sweep(1'b0, 5'h15, 32'h400, 32'h9000, 32'd0, 32'd3, 1, 1'b0);

        for (int i = 0; i < 20; i++) begin
            np  = $urandom_range(5, 1);
            inc = $urandom_range(32'h10_0000, 1);
            st  = $urandom_range(32'h2000_0000, 0);
            sp  = st + 32'(np - 1) * inc + $urandom_range(inc - 1, 0);
            run_sweep(1'($urandom), 5'($urandom), st, sp, inc, $urandom_range(6, 0),
                      $urandom_range(4, 1), 1'b1);
        end

        // abort in IDLE leaves sticky done alone
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        tick();
        check("idle_abort_done", done_o, 1);
        check("idle_abort_busy", busy_o, 0);

        // ack timeout
        ack_mode = 1;
        set_cfg(1'b0, 5'd3, 32'h100, 32'h300, 32'h100, 32'd2);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        t0 = cyc;
        check("tmo_first_wen", m_wen_o, 1);
        n = 0;
        while (!err_o && n < 100) begin
            tick();
            n++;
        end
        check("tmo_cycles", 64'(cyc - t0), 64'(ACK_TMO));
        check("tmo_busy", busy_o, 1);
        check("tmo_done", done_o, 0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        check("err_start_ignored", {err_o, busy_o}, 2'b11);
        check("err_no_writes", 64'(obs_q.size()), 1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("err_abort_busy", busy_o, 0);
        check("err_abort_err", err_o, 1);

        // slave error response on the first write
        ack_mode = 2;
        lat_min = 1; lat_max = 2;
        set_cfg(1'b1, 5'd7, 32'h100, 32'h300, 32'h100, 32'd2);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("start_clears_err", err_o, 0);
        n = 0;
        while (!err_o && n < 100) begin
            tick();
            n++;
        end
        check("berr_err", err_o, 1);
        check("berr_done", done_o, 0);
        check("berr_writes", 64'(obs_q.size()), 1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        ack_mode = 0;

        // abort while dwelling on point 1
        lat_min = 1; lat_max = 1;
        set_cfg(1'b0, 5'd0, 32'h0, 32'h500, 32'h100, 32'd20);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n = 0;
        while (obs_q.size() < 4 && n < 500) begin
            tick();
            n++;
        end
        check("abort_reach_pt1", 64'(n < 500), 1);
        repeat (3) tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("abort_busy", busy_o, 0);
        check("abort_done", done_o, 0);
        check("abort_point", point_o, 1);
        repeat (40) tick();
        check("abort_no_more_wr", 64'(obs_q.size()), 4);
        check("abort_done_late", done_o, 0);

        // start and abort together in IDLE: start wins
        set_cfg(1'b0, 5'd2, 32'h50, 32'h10, 32'h1, 32'd1);
        start_i = 1'b1;
        abort_i = 1'b1;
        tick();
        start_i = 1'b0;
        abort_i = 1'b0;
        check("start_wins_busy", busy_o, 1);
        wait_idle("start_wins_timeout");
        check("start_wins_done", done_o, 1);
        check("start_wins_writes", 64'(obs_q.size()), 2);

        // reset while waiting for the trigger ack; ack lands after reset
        lat_min = 2; lat_max = 2;
        set_cfg(1'b1, 5'd9, 32'h100, 32'h900, 32'h100, 32'd3);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n = 0;
        while (!(m_wen_o && m_addr_o == 32'h0) && n < 200) begin
            tick();
            n++;
        end
        check("rst_reach_trig", 64'(n < 200), 1);
        tick();
        dac_rst_i = 1'b1;
        tick();
        dac_rst_i = 1'b0;
        repeat (10) tick();
        check("rst2_busy", busy_o, 0);
        check("rst2_done", done_o, 0);
        check("rst2_err", err_o, 0);
        check("rst2_point", point_o, 0);
        check("rst2_addr", m_addr_o, 0);
        check("rst2_wdata", m_wdata_o, 0);
        check("rst2_wen", m_wen_o, 0);
        check("rst2_writes", 64'(obs_q.size()), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        bad++;
        $display("FAIL watchdog: simulation did not complete, cycle=%0d", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
